// File: rtl/axis_multichannel_frame_master.sv
// AXI4-Stream master that buffers per-channel samples in a FIFO and emits them as
// complete frames of NUM_CHANNELS beats, with a programmable idle gap between frames.
module axis_multichannel_frame_master #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ID_BUS_WIDTH   = 8,
  parameter int DEST_BUS_WIDTH = 4,
  parameter int USER_BUS_WIDTH = 8,
  parameter int NUM_CHANNELS   = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int GAP_WIDTH      = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          s_wr,
  input  logic [DATA_BUS_WIDTH-1:0]     s_data,
  output logic                          s_full,
  output logic [$clog2(FIFO_DEPTH):0]   s_level,
  input  logic                          cfg_enable,
  input  logic [DEST_BUS_WIDTH-1:0]     cfg_dest,
  input  logic [GAP_WIDTH-1:0]          cfg_gap,
  output logic                          TVALID,
  input  logic                          TREADY,
  output logic [DATA_BUS_WIDTH-1:0]     TDATA,
  output logic [DATA_BUS_WIDTH/8-1:0]   TSTRB,
  output logic [DATA_BUS_WIDTH/8-1:0]   TKEEP,
  output logic                          TLAST,
  output logic [ID_BUS_WIDTH-1:0]       TID,
  output logic [DEST_BUS_WIDTH-1:0]     TDEST,
  output logic [USER_BUS_WIDTH-1:0]     TUSER,
  output logic [31:0]                   frame_count,
  output logic                          overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int STRB_W  = DATA_BUS_WIDTH / 8;
  localparam int LAST_CH = NUM_CHANNELS - 1;
  localparam logic [PTR_W:0]          FRAME_LEVEL = NUM_CHANNELS[PTR_W:0];
  localparam logic [PTR_W:0]          DEPTH_LEVEL = FIFO_DEPTH[PTR_W:0];
  localparam logic [ID_BUS_WIDTH-1:0] LAST_ID     = LAST_CH[ID_BUS_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [DATA_BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [PTR_W:0]            count_q, count_d;
  logic                      overflow_q;
  logic                      wr_en, rd_en;

  state_t                    state_q;
  logic                      tvalid_q, tlast_q;
  logic [DATA_BUS_WIDTH-1:0] tdata_q;
  logic [ID_BUS_WIDTH-1:0]   tid_q, tid_nxt;
  logic [DEST_BUS_WIDTH-1:0] tdest_q;
  logic [USER_BUS_WIDTH-1:0] tuser_q;
  logic [GAP_WIDTH-1:0]      gap_cnt_q;
  logic [31:0]               frame_cnt_q;

  // Full is taken from the registered count, so a same-cycle pop never admits a write at full.
  assign s_full     = (count_q == DEPTH_LEVEL);
  assign s_level    = count_q;
  assign wr_en      = s_wr && !s_full;
  assign rd_en      = tvalid_q && TREADY;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;
  assign tid_nxt    = tid_q + 1'b1;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sample storage carries no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_d;
      if (s_wr && s_full) overflow_q <= 1'b1;
    end
  end

  // Frame FSM; every stream output is a register so TVALID never follows TREADY combinationally.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      tuser_q     <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_enable && (count_q >= FRAME_LEVEL)) begin
            state_q  <= SEND;
            tvalid_q <= 1'b1;
            tdata_q  <= mem_q[rd_ptr_q];
            tid_q    <= '0;
            tlast_q  <= (NUM_CHANNELS == 1);
            tdest_q  <= cfg_dest;
            tuser_q  <= frame_cnt_q[USER_BUS_WIDTH-1:0];
          end
        end
        SEND: begin
          if (tvalid_q && TREADY) begin
            if (tlast_q) begin
              tvalid_q    <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 32'd1;
              gap_cnt_q   <= cfg_gap;
              state_q     <= (cfg_gap != '0) ? GAP : IDLE;
            end else begin
              tdata_q <= mem_q[rd_ptr_nxt];
              tid_q   <= tid_nxt;
              tlast_q <= (tid_nxt == LAST_ID);
            end
          end
        end
        GAP: begin
          // Leaving on a count of one makes the IDLE cycle the final idle cycle of the gap.
          gap_cnt_q <= gap_cnt_q - 1'b1;
          if (gap_cnt_q <= GAP_WIDTH'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TVALID      = tvalid_q;
  assign TDATA       = tdata_q;
  assign TSTRB       = {STRB_W{tvalid_q}};
  assign TKEEP       = {STRB_W{tvalid_q}};
  assign TLAST       = tlast_q;
  assign TID         = tid_q;
  assign TDEST       = tdest_q;
  assign TUSER       = tuser_q;
  assign frame_count = frame_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_axis_multichannel_frame_master.sv
// Directed bench for axis_multichannel_frame_master: framing, stalls, gaps, overflow and reset.
module tb_axis_multichannel_frame_master;

  localparam int DW = 32, IDW = 8, DSW = 4, UW = 8, NCH = 2, DEPTH = 16, GW = 8;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic            s_wr = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            s_full;
  logic [4:0]      s_level;
  logic            cfg_enable = 1'b0;
  logic [DSW-1:0]  cfg_dest = '0;
  logic [GW-1:0]   cfg_gap = '0;
  logic            TVALID;
  logic            TREADY = 1'b0;
  logic [DW-1:0]   TDATA;
  logic [DW/8-1:0] TSTRB, TKEEP;
  logic            TLAST;
  logic [IDW-1:0]  TID;
  logic [DSW-1:0]  TDEST;
  logic [UW-1:0]   TUSER;
  logic [31:0]     frame_count;
  logic            overflow;

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic           last;
    logic [UW-1:0]  user;
    logic [DSW-1:0] dest;
  } beat_t;

  beat_t beats[$];
  int    gap_runs[$];
  bit    gap_mon_en = 1'b0;
  int    low_run = 0;
  bit    seen_valid = 1'b0;
  int    checks = 0;
  int    errors = 0;

  axis_multichannel_frame_master #(
    .DATA_BUS_WIDTH(DW), .ID_BUS_WIDTH(IDW), .DEST_BUS_WIDTH(DSW), .USER_BUS_WIDTH(UW),
    .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .GAP_WIDTH(GW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_wr(s_wr), .s_data(s_data), .s_full(s_full),
    .s_level(s_level), .cfg_enable(cfg_enable), .cfg_dest(cfg_dest), .cfg_gap(cfg_gap),
    .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TSTRB(TSTRB), .TKEEP(TKEEP),
    .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .TUSER(TUSER), .frame_count(frame_count),
    .overflow(overflow)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change 1ns after the rising edge, so the falling edge sees what the next edge will take.
  always @(negedge ACLK) begin
    beat_t b;
    if (!ARESET && TVALID && TREADY) begin
      b.data = TDATA; b.id = TID; b.last = TLAST; b.user = TUSER; b.dest = TDEST;
      beats.push_back(b);
    end
    if (gap_mon_en) begin
      if (TVALID) begin
        if (seen_valid && low_run > 0) gap_runs.push_back(low_run);
        low_run = 0;
        seen_valid = 1'b1;
      end else if (seen_valid) begin
        low_run++;
      end
    end else begin
      low_run = 0;
      seen_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1; s_wr = 1'b0; cfg_enable = 1'b0; TREADY = 1'b0;
    step(); step();
    ARESET = 1'b0;
    beats.delete();
  endtask

  task automatic write_sample(input logic [DW-1:0] d);
    s_wr = 1'b1; s_data = d;
    step();
    s_wr = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frame_count != target && n < budget) begin step(); n++; end
    checks++;
    if (frame_count !== target) begin
      errors++;
      $display("FAIL %s: frame_count=%0d required %0d", name, frame_count, target);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (TVALID !== 1'b1 && n < budget) begin step(); n++; end
    checks++;
    if (TVALID !== 1'b1) begin
      errors++;
      $display("FAIL %s: TVALID=%b required 1 within %0d cycles", name, TVALID, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", TVALID); end
    checks++; if (TDATA !== '0) begin errors++; $display("FAIL reset_tdata: got %h required 0", TDATA); end
    checks++; if (TSTRB !== '0 || TKEEP !== '0) begin errors++; $display("FAIL reset_strb: got %h/%h required 0/0", TSTRB, TKEEP); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_frame_count: got %0d required 0", frame_count); end
    checks++; if (s_level !== 5'd0 || s_full !== 1'b0) begin errors++; $display("FAIL reset_fifo: level=%0d full=%b required 0/0", s_level, s_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_basic_frame();
    cfg_enable = 1'b1; cfg_gap = '0; cfg_dest = 4'h5; TREADY = 1'b1;
    beats.delete();
    write_sample(32'hA0A0_0000);
    write_sample(32'hB0B0_0000);
    checks++; if (TVALID !== 1'b0) begin errors++; $display("FAIL basic_latency_early: TVALID=%b required 0", TVALID); end
    step();
    checks++;
    if (TVALID !== 1'b1 || TDATA !== 32'hA0A0_0000 || TID !== 8'd0 || TLAST !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_beat: valid=%b data=%h id=%0d last=%b required 1/a0a00000/0/0", TVALID, TDATA, TID, TLAST);
    end
    checks++;
    if (TDEST !== 4'h5 || TUSER !== 8'd0 || TKEEP !== 4'hF || TSTRB !== 4'hF) begin
      errors++;
      $display("FAIL basic_sideband: dest=%h user=%0d keep=%h strb=%h required 5/0/f/f", TDEST, TUSER, TKEEP, TSTRB);
    end
    wait_frames(1, 10, "basic_frame_done");
    checks++;
    if (beats.size() !== 2) begin
      errors++; $display("FAIL basic_beat_count: got %0d required 2", beats.size());
    end else if (beats[0].data !== 32'hA0A0_0000 || beats[0].id !== 8'd0 || beats[0].last !== 1'b0 ||
                 beats[1].data !== 32'hB0B0_0000 || beats[1].id !== 8'd1 || beats[1].last !== 1'b1) begin
      errors++;
      $display("FAIL basic_beats: got %h/%0d/%b %h/%0d/%b required a0a00000/0/0 b0b00000/1/1",
               beats[0].data, beats[0].id, beats[0].last, beats[1].data, beats[1].id, beats[1].last);
    end
    checks++; if (s_level !== 5'd0) begin errors++; $display("FAIL basic_level: got %0d required 0", s_level); end
  endtask

  task automatic test_partial_frame();
    beats.delete();
    write_sample(32'h0000_0C00);
    write_sample(32'h0000_0C01);
    write_sample(32'h0000_0C02);
    wait_frames(2, 20, "partial_frame_done");
    repeat (4) step();
    checks++; if (TVALID !== 1'b0) begin errors++; $display("FAIL partial_tvalid: got %b required 0", TVALID); end
    checks++; if (s_level !== 5'd1) begin errors++; $display("FAIL partial_level: got %0d required 1", s_level); end
    checks++; if (frame_count !== 32'd2) begin errors++; $display("FAIL partial_frames: got %0d required 2", frame_count); end
    checks++;
    if (beats.size() !== 2) begin
      errors++; $display("FAIL partial_beat_count: got %0d required 2", beats.size());
    end else if (beats[0].data !== 32'h0C00 || beats[1].data !== 32'h0C01 || beats[0].user !== 8'd1) begin
      errors++;
      $display("FAIL partial_beats: got %h %h user=%0d required c00 c01 user=1", beats[0].data, beats[1].data, beats[0].user);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cfg_enable = 1'b1; cfg_gap = '0; TREADY = 1'b0;
    write_sample(32'hD000_0000);
    write_sample(32'hD000_0001);
    wait_valid(10, "stall_start");
    checks++; if (TDATA !== 32'hD000_0000 || TID !== 8'd0) begin errors++; $display("FAIL stall_beat0: data=%h id=%0d required d0000000/0", TDATA, TID); end
    TREADY = 1'b1;
    step();
    TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TVALID !== 1'b1 || TDATA !== 32'hD000_0001 || TID !== 8'd1 || TLAST !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b data=%h id=%0d last=%b required 1/d0000001/1/1", i, TVALID, TDATA, TID, TLAST);
      end
      if (i < 2) step();
    end
    TREADY = 1'b1;
    step();
    checks++; if (TVALID !== 1'b0 || frame_count !== 32'd1) begin errors++; $display("FAIL stall_done: valid=%b frames=%0d required 0/1", TVALID, frame_count); end
    checks++;
    if (beats.size() !== 2) begin
      errors++; $display("FAIL stall_beat_count: got %0d required 2", beats.size());
    end else if (beats[0].data !== 32'hD000_0000 || beats[1].data !== 32'hD000_0001) begin
      errors++; $display("FAIL stall_beats: got %h %h required d0000000 d0000001", beats[0].data, beats[1].data);
    end
  endtask

  task automatic test_gap();
    do_reset();
    gap_runs.delete();
    gap_mon_en = 1'b1;
    cfg_gap = 8'd3; cfg_dest = 4'hA; TREADY = 1'b1;
    for (int i = 0; i < 8; i++) write_sample(32'h0000_0E00 + i);
    cfg_enable = 1'b1;
    wait_frames(4, 100, "gap_frames_done");
    gap_mon_en = 1'b0;
    checks++;
    if (gap_runs.size() !== 3) begin
      errors++; $display("FAIL gap_run_count: got %0d required 3", gap_runs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gap_runs[i] !== 4) begin errors++; $display("FAIL gap_run_%0d: got %0d idle cycles required 4", i, gap_runs[i]); end
      end
    end
    checks++;
    if (beats.size() !== 8) begin
      errors++; $display("FAIL gap_beat_count: got %0d required 8", beats.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (beats[i].data !== 32'h0E00 + i || beats[i].id !== IDW'(i % 2) || beats[i].last !== ((i % 2) == 1) ||
            beats[i].user !== UW'(i / 2) || beats[i].dest !== 4'hA) begin
          errors++;
          $display("FAIL gap_beat_%0d: data=%h id=%0d last=%b user=%0d dest=%h required %h/%0d/%0d/%0d/a",
                   i, beats[i].data, beats[i].id, beats[i].last, beats[i].user, beats[i].dest,
                   32'h0E00 + i, i % 2, i % 2, i / 2);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit found;
    do_reset();
    cfg_gap = '0; TREADY = 1'b1;
    for (int i = 0; i < 15; i++) write_sample(32'h0000_0F00 + i);
    checks++; if (s_level !== 5'd15 || s_full !== 1'b0) begin errors++; $display("FAIL ovf_at15: level=%0d full=%b required 15/0", s_level, s_full); end
    write_sample(32'h0000_0F0F);
    checks++; if (s_level !== 5'd16 || s_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_at16: level=%0d full=%b ovf=%b required 16/1/0", s_level, s_full, overflow); end
    write_sample(32'h0000_0F10);
    checks++; if (s_level !== 5'd16 || s_full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_at17: level=%0d full=%b ovf=%b required 16/1/1", s_level, s_full, overflow); end
    cfg_enable = 1'b1;
    wait_frames(8, 200, "ovf_drain");
    repeat (3) step();
    found = 1'b0;
    foreach (beats[i]) if (beats[i].data === 32'h0F10) found = 1'b1;
    checks++; if (beats.size() !== 16 || found) begin errors++; $display("FAIL ovf_drain_beats: count=%0d dropped_seen=%b required 16/0", beats.size(), found); end
    checks++; if (overflow !== 1'b1 || s_level !== 5'd0) begin errors++; $display("FAIL ovf_sticky: ovf=%b level=%0d required 1/0", overflow, s_level); end
  endtask

  task automatic test_reset_mid_frame();
    // Starts from the overflowed, eight-frame state so the reset has counters to clear.
    beats.delete();
    cfg_enable = 1'b1; TREADY = 1'b0;
    write_sample(32'h0000_0700);
    write_sample(32'h0000_0701);
    wait_valid(10, "rst_mid_start");
    TREADY = 1'b1;
    step();
    TREADY = 1'b0;
    checks++; if (TID !== 8'd1 || TVALID !== 1'b1) begin errors++; $display("FAIL rst_mid_stall: id=%0d valid=%b required 1/1", TID, TVALID); end
    step();
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    checks++; if (TVALID !== 1'b0 || TDATA !== '0) begin errors++; $display("FAIL rst_mid_tvalid: valid=%b data=%h required 0/0", TVALID, TDATA); end
    checks++; if (s_level !== 5'd0 || frame_count !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_state: level=%0d frames=%0d ovf=%b required 0/0/0", s_level, frame_count, overflow); end
    repeat (3) step();
    checks++; if (TVALID !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: valid=%b required 0", TVALID); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_partial_frame();
    test_stall();
    test_gap();
    test_overflow();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
